mmio_uart_tx: RTL and testbench

//   Memory-mapped UART transmitter on the processor's data bus, beside dmem.

---
 rtl/uart_pkg.sv | 7 +
 rtl/sync_fifo.sv | 38 +++
 rtl/mmio_uart_tx.sv | 75 +++++++
 tb/tb_mmio_uart_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared framing-state type and status-word bit positions
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF  = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO that accepts a push while full when a pop lands on the same edge
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-bus snooping UART transmitter with byte FIFO and pollable status word
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_0104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  tx_state_t state;
  logic [BW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh, dout;
  logic full, empty, ovf, wr_tx, wr_st, pop, tick;
  logic [$clog2(FIFO_DEPTH+1)-1:0] unused_cnt;
  logic unused_wd;
  assign unused_wd = ^WriteData[31:8];
  assign wr_tx = MemWrite && DataAdr == TX_ADDR;
  assign wr_st = MemWrite && DataAdr == STATUS_ADDR && WriteData[STAT_OVF];
  assign pop   = state == IDLE && !empty;
  assign tick  = cnt == BW'(CLKS_PER_BIT - 1);
  assign busy  = state != IDLE || !empty;
  assign tx    = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
  always_comb begin
    ReadData = '0;
    ReadData[STAT_BUSY] = busy;
    ReadData[STAT_FULL] = full;
    ReadData[STAT_OVF]  = ovf;
    ReadData = DataAdr == STATUS_ADDR ? ReadData : '0;
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr_tx), .pop(pop), .din(WriteData[7:0]),
    .dout(dout), .full(full), .empty(empty), .count(unused_cnt)
  );
  // a drop and a clear on the same edge leave the flag set
  always_ff @(posedge clk or posedge reset)
    if (reset) ovf <= 1'b0;
    else if (wr_tx && full && !pop) ovf <= 1'b1;
    else if (wr_st) ovf <= 1'b0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      case (state)
        IDLE:  if (!empty) begin
                 state <= START;
                 sh    <= dout;
               end
        START: if (tick) begin
                 state <= DATA;
                 idx   <= '0;
               end
        DATA:  if (tick) begin
                 sh    <= sh >> 1;
                 idx   <= idx + 1'b1;
                 state <= idx == 3'd7 ? STOP : DATA;
               end
        default: if (tick) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench decoding the serial line against queued store bytes
module tb_mmio_uart_tx;
  localparam logic [31:0] TXA = 32'h0000_0100;
  localparam logic [31:0] STA = 32'h0000_0104;
  logic clk = 0, reset = 1, MemWrite = 0;
  logic [31:0] DataAdr = STA, WriteData = 0, ReadData;
  logic tx, busy;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .TX_ADDR(TXA), .STATUS_ADDR(STA)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .tx(tx), .busy(busy)
  );
  always #5 clk = ~clk;

  logic mon_ok, mon_stop;
  logic [7:0] mon_byte, mon_exp;
  always begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      mon_ok = 1;
      mon_byte = 0;
      mon_stop = 0;
      for (int k = 1; k <= 38 && mon_ok; k++) begin
        @(negedge clk);
        if (reset) mon_ok = 0;
        else if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) mon_byte[(k-6)/4] = tx;
        else if (k == 38) mon_stop = tx;
      end
      if (mon_ok) begin
        checks++;
        if (mon_stop !== 1'b1) begin errors++; $display("FAIL mon_stop got %b want 1", mon_stop); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL mon_byte got %h want none", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_byte !== mon_exp) begin errors++; $display("FAIL mon_byte got %h want %h", mon_byte, mon_exp); end
        end
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit exp);
    MemWrite = 1; DataAdr = a; WriteData = d;
    if (exp) exp_q.push_back(d[7:0]);
    @(posedge clk); #1;
    MemWrite = 0; DataAdr = STA;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle busy got %b want 0", busy); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got %b want 1", tx); end
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 0", ReadData); end
    reset = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL rst_after got busy=%b tx=%b want 0,1", busy, tx); end
  endtask

  task automatic test_frame;
    logic [9:0] fr = {1'b1, 8'h55, 1'b0};
    store(TXA, 32'h55, 1);
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_k0 got %b want 1", tx); end
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k <= 40) begin
        checks++;
        if (tx !== fr[(k-1)/4]) begin errors++; $display("FAIL frame_k%0d got %b want %b", k, tx, fr[(k-1)/4]); end
      end
      if (k >= 40) begin
        checks++;
        if (busy !== (k == 40)) begin errors++; $display("FAIL frame_busy_k%0d got %b want %b", k, busy, k == 40); end
      end
    end
  endtask

  task automatic test_back_to_back;
    store(TXA, 32'h41, 1);
    store(TXA, 32'h42, 1);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 41) begin
        checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_gap got tx=%b busy=%b want 1,1", tx, busy); end
      end
      if (k == 42) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start2 got %b want 0", tx); end
      end
    end
    wait_idle(200);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 6; i++) store(TXA, 32'(i), i < 5);
    #1;
    checks++; if (ReadData !== 32'h7) begin errors++; $display("FAIL ovf_status got %h want 7", ReadData); end
    store(STA, 32'h4, 0);
    #1;
    checks++; if (ReadData[2] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ReadData[2]); end
    wait_idle(400);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL ovf_final got %h want 0", ReadData); end
  endtask

  task automatic test_reset_midframe;
    store(TXA, 32'hA5, 1);
    repeat (15) @(posedge clk);
    #1 reset = 1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", tx); end
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL midrst_status got %h want 0", ReadData); end
    repeat (2) @(posedge clk);
    #1 reset = 0;
    exp_q.delete();
    store(TXA, 32'h3C, 1);
    wait_idle(100);
  endtask

  task automatic test_ignored;
    bit low = 0;
    store(32'h108, 32'h99, 0);
    DataAdr = TXA;
    #1;
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL ign_rd got %h want 0", ReadData); end
    for (int k = 0; k < 50; k++) begin @(negedge clk); if (tx !== 1'b1) low = 1; end
    checks++; if (low) begin errors++; $display("FAIL ign_tx got low want high"); end
    DataAdr = STA;
    #1;
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL ign_status got %h want 0", ReadData); end
  endtask

  task automatic test_push_pop_full;
    for (int i = 0; i < 5; i++) store(TXA, 32'h10 + 32'(i), 1);
    #1;
    checks++; if (ReadData !== 32'h3) begin errors++; $display("FAIL ppf_full got %h want 3", ReadData); end
    repeat (37) @(posedge clk);
    #1;
    store(TXA, 32'h15, 1);
    #1;
    checks++; if (ReadData !== 32'h3) begin errors++; $display("FAIL ppf_status got %h want 3", ReadData); end
    wait_idle(400);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_ignored();
    test_push_pop_full();
    repeat (5) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_left got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
